cdb_arbiter: RTL and testbench

Common-data-bus arbiter placed between the result producers (reservation-station ALU, load & store buffer) and the result consumers (reorder buffer, reservation station, load & store buffer). It merges the two independent result streams onto one registered broadcast bus, at most one result per cycle. Short per-source FIFOs absorb collisions, and round-robin arbitration guarantees forward progress. A flush input empties all queued results on branch misprediction.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_arbiter_if.sv | 43 ++++
 rtl/cdb_fifo.sv | 64 ++++++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: constants and types shared by the common-data-bus arbiter,
// its queues, its interface and its testbench.
//   ROB_WIDTH    default width of a reorder-buffer index
//   CDB_ENTRY_W  width of one queued/broadcast entry {robId, value}
//   cdbSrc_e     result source identifiers (SRC_ALU, SRC_LSB)
//   entryWidth() entry width for an arbitrary ROB index width
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH   = 4;
  localparam int CDB_ENTRY_W = ROB_WIDTH + 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdbSrc_e;

  function automatic int entryWidth(input int robWidth);
    return robWidth + 32;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle of producer, flush and broadcast signals around the
// common-data-bus arbiter.
//   flush                        misprediction clear (active-high)
//   aluValid/aluRobId/aluVal     ALU result stream, aluStall back-pressure
//   lsbValid/lsbRobId/lsbVal     LSB result stream, lsbStall back-pressure
//   cdbValid/cdbRobId/cdbVal     registered broadcast bus
// Modport slave is the arbiter's view, master the environment's view.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = cdb_arbiter_pkg::ROB_WIDTH
);

  logic                 flush;
  logic                 aluValid;
  logic [ROB_WIDTH-1:0] aluRobId;
  logic [31:0]          aluVal;
  logic                 aluStall;
  logic                 lsbValid;
  logic [ROB_WIDTH-1:0] lsbRobId;
  logic [31:0]          lsbVal;
  logic                 lsbStall;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobId;
  logic [31:0]          cdbVal;

  modport master (
    output flush,
    output aluValid, aluRobId, aluVal,
    input  aluStall,
    output lsbValid, lsbRobId, lsbVal,
    input  lsbStall,
    input  cdbValid, cdbRobId, cdbVal
  );

  modport slave (
    input  flush,
    input  aluValid, aluRobId, aluVal,
    output aluStall,
    input  lsbValid, lsbRobId, lsbVal,
    output lsbStall,
    output cdbValid, cdbRobId, cdbVal
  );

endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: small per-source result queue for the CDB arbiter.
//   clockIn   clock, rising edge
//   resetIn   synchronous active-low reset (pointers and count)
//   flush     empties the queue; overrides push and pop
//   push      write pushData at the tail
//   pushData  entry to enqueue
//   pop       drop the head entry
//   count     occupancy, 0..2**FIFO_WIDTH
//   head      current head entry (undefined when count is 0)
module cdb_fifo #(
  parameter int FIFO_WIDTH = 2,
  parameter int DATA_W     = 36
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     pushData,
  input  logic                  pop,
  output logic [FIFO_WIDTH:0]   count,
  output logic [DATA_W-1:0]     head
);

  localparam int DEPTH = 1 << FIFO_WIDTH;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wrPtr;
  logic [FIFO_WIDTH-1:0] rdPtr;
  logic                  doPush;
  logic                  doPop;

  // Full/empty come from the count; pointers simply wrap modulo DEPTH.
  // A push into a full queue is only honoured when a pop frees a slot.
  assign doPop  = pop && (count != '0);
  assign doPush = push && ((count != (FIFO_WIDTH+1)'(DEPTH)) || doPop);

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the count decides what is valid.
  always_ff @(posedge clockIn) begin
    if (resetIn && !flush && doPush) mem[wrPtr] <= pushData;
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges the ALU and LSB result streams onto one registered
// common data bus, at most one broadcast per cycle.
//   clockIn   clock, rising edge
//   resetIn   synchronous active-low reset
//   cdbBus    slave modport: flush, both producer streams with their stall
//             outputs, and the broadcast cdbValid/cdbRobId/cdbVal
// Each source owns a cdb_fifo; an empty queue lets the same-cycle input
// bypass straight to arbitration. Conflicts are resolved round-robin.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int FIFO_WIDTH = 2
) (
  input  logic         clockIn,
  input  logic         resetIn,
  cdb_arbiter_if.slave cdbBus
);

  import cdb_arbiter_pkg::*;

  localparam int ENTRY_W = entryWidth(ROB_WIDTH);
  localparam int DEPTH   = 1 << FIFO_WIDTH;
  localparam int COUNT_W = FIFO_WIDTH + 1;

  logic [COUNT_W-1:0]   aluCount;
  logic [COUNT_W-1:0]   lsbCount;
  logic [ENTRY_W-1:0]   aluHead;
  logic [ENTRY_W-1:0]   lsbHead;
  logic [ENTRY_W-1:0]   aluEntry;
  logic [ENTRY_W-1:0]   lsbEntry;
  logic                 aluHas;
  logic                 lsbHas;
  logic                 aluCand;
  logic                 lsbCand;
  logic                 conflict;
  logic                 grantAlu;
  logic                 grantLsb;
  logic                 aluPush;
  logic                 lsbPush;
  logic                 aluPop;
  logic                 lsbPop;
  logic [ENTRY_W-1:0]   winEntry;

  cdbSrc_e              lastGrant;
  logic                 cdbValidReg;
  logic [ROB_WIDTH-1:0] cdbRobIdReg;
  logic [31:0]          cdbValReg;

  cdb_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .DATA_W     (ENTRY_W)
  ) aluFifo (
    .clockIn  (clockIn),
    .resetIn  (resetIn),
    .flush    (cdbBus.flush),
    .push     (aluPush),
    .pushData ({cdbBus.aluRobId, cdbBus.aluVal}),
    .pop      (aluPop),
    .count    (aluCount),
    .head     (aluHead)
  );

  cdb_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .DATA_W     (ENTRY_W)
  ) lsbFifo (
    .clockIn  (clockIn),
    .resetIn  (resetIn),
    .flush    (cdbBus.flush),
    .push     (lsbPush),
    .pushData ({cdbBus.lsbRobId, cdbBus.lsbVal}),
    .pop      (lsbPop),
    .count    (lsbCount),
    .head     (lsbHead)
  );

  // Candidate selection and round-robin grant. A queued entry always takes
  // precedence over the new input so per-source order is preserved.
  always_comb begin
    aluHas   = (aluCount != '0);
    lsbHas   = (lsbCount != '0);
    aluCand  = aluHas || cdbBus.aluValid;
    lsbCand  = lsbHas || cdbBus.lsbValid;
    aluEntry = aluHas ? aluHead : {cdbBus.aluRobId, cdbBus.aluVal};
    lsbEntry = lsbHas ? lsbHead : {cdbBus.lsbRobId, cdbBus.lsbVal};
    conflict = aluCand && lsbCand;
    grantAlu = aluCand && (!lsbCand || (lastGrant == SRC_LSB));
    grantLsb = lsbCand && !grantAlu;
    aluPop   = grantAlu && aluHas;
    lsbPop   = grantLsb && lsbHas;
    // Only an input that bypassed and won skips the queue.
    aluPush  = cdbBus.aluValid && !(grantAlu && !aluHas);
    lsbPush  = cdbBus.lsbValid && !(grantLsb && !lsbHas);
    winEntry = grantAlu ? aluEntry : lsbEntry;
  end

  // Broadcast registers: winner becomes visible in the cycle after the grant.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      cdbValidReg <= 1'b0;
      cdbRobIdReg <= '0;
      cdbValReg   <= '0;
      lastGrant   <= SRC_LSB;
    end else if (cdbBus.flush) begin
      cdbValidReg <= 1'b0;
    end else begin
      cdbValidReg <= grantAlu || grantLsb;
      if (grantAlu || grantLsb) begin
        cdbRobIdReg <= winEntry[ENTRY_W-1:32];
        cdbValReg   <= winEntry[31:0];
      end
      if (conflict) lastGrant <= grantAlu ? SRC_ALU : SRC_LSB;
    end
  end

  // Stall leaves room for the one result already in flight in the producer.
  assign cdbBus.aluStall = (aluCount >= COUNT_W'(DEPTH - 1));
  assign cdbBus.lsbStall = (lsbCount >= COUNT_W'(DEPTH - 1));
  assign cdbBus.cdbValid = cdbValidReg;
  assign cdbBus.cdbRobId = cdbRobIdReg;
  assign cdbBus.cdbVal   = cdbValReg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic for cdb_arbiter,
// compared cycle by cycle against a queue-based reference model.
module tb_cdb_arbiter;

  import cdb_arbiter_pkg::*;

  localparam int RW = ROB_WIDTH;
  localparam int EW = CDB_ENTRY_W;

  logic clockIn = 1'b0;
  logic resetIn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  cdb_arbiter_if #(.ROB_WIDTH(RW)) bus();

  cdb_arbiter #(
    .ROB_WIDTH  (RW),
    .FIFO_WIDTH (2)
  ) dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .cdbBus  (bus)
  );

  always #5 clockIn = ~clockIn;

  // Reference model: each source is an ordered list of pending results.
  logic [EW-1:0] aluQ[$];
  logic [EW-1:0] lsbQ[$];
  cdbSrc_e       mLast;
  logic          mValid;
  logic [RW-1:0] mRob;
  logic [31:0]   mVal;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // New input joins the back of its source's list; the round-robin winner
  // leaves from the front. An empty list therefore means the input bypasses.
  task automatic modelEdge(input logic aV, input logic [EW-1:0] aE,
                           input logic lV, input logic [EW-1:0] lE,
                           input logic fl, input logic rn);
    bit            winA;
    bit            winL;
    logic [EW-1:0] w;
    if (!rn) begin
      aluQ.delete();
      lsbQ.delete();
      mValid = 1'b0;
      mRob   = '0;
      mVal   = '0;
      mLast  = SRC_LSB;
    end else if (fl) begin
      aluQ.delete();
      lsbQ.delete();
      mValid = 1'b0;
    end else begin
      if (aV) aluQ.push_back(aE);
      if (lV) lsbQ.push_back(lE);
      winA = (aluQ.size() > 0) && ((lsbQ.size() == 0) || (mLast == SRC_LSB));
      winL = (lsbQ.size() > 0) && !winA;
      if ((aluQ.size() > 0) && (lsbQ.size() > 0)) mLast = winA ? SRC_ALU : SRC_LSB;
      w = '0;
      if (winA)      w = aluQ.pop_front();
      else if (winL) w = lsbQ.pop_front();
      mValid = winA || winL;
      if (mValid) begin
        mRob = w[EW-1:32];
        mVal = w[31:0];
      end
    end
  endtask

  task automatic step(input logic aV, input logic [RW-1:0] aR, input logic [31:0] aD,
                      input logic lV, input logic [RW-1:0] lR, input logic [31:0] lD,
                      input logic fl, input logic rn);
    bus.aluValid = aV;
    bus.aluRobId = aR;
    bus.aluVal   = aD;
    bus.lsbValid = lV;
    bus.lsbRobId = lR;
    bus.lsbVal   = lD;
    bus.flush    = fl;
    resetIn      = rn;
    modelEdge(aV, {aR, aD}, lV, {lR, lD}, fl, rn);
    @(posedge clockIn);
    #1;
    checkEq("cdbValid", bus.cdbValid, mValid);
    checkEq("cdbRobId", bus.cdbRobId, mRob);
    checkEq("cdbVal",   bus.cdbVal,   mVal);
    checkEq("aluStall", bus.aluStall, aluQ.size() >= 3);
    checkEq("lsbStall", bus.lsbStall, lsbQ.size() >= 3);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bit pA;
    bit pL;
    bit curA;
    bit curL;
    mLast  = SRC_LSB;
    mValid = 1'b0;
    mRob   = '0;
    mVal   = '0;
    bus.flush = 1'b0;
    bus.aluValid = 1'b0; bus.aluRobId = '0; bus.aluVal = '0;
    bus.lsbValid = 1'b0; bus.lsbRobId = '0; bus.lsbVal = '0;

    // Reset state
    doReset();
    doReset();
    checkEq("rst_valid", bus.cdbValid, 1'b0);
    checkEq("rst_rob",   bus.cdbRobId, 4'd0);
    checkEq("rst_val",   bus.cdbVal,   32'd0);

    // ALU only, one-cycle latency
    step(1'b1, 4'd3, 32'h10, 1'b0, '0, '0, 1'b0, 1'b1);
    checkEq("alu_only_valid", bus.cdbValid, 1'b1);
    checkEq("alu_only_rob",   bus.cdbRobId, 4'd3);
    checkEq("alu_only_val",   bus.cdbVal,   32'h10);
    checkEq("alu_only_stall", {bus.aluStall, bus.lsbStall}, 2'b00);

    // First conflict goes to the ALU, LSB follows next cycle
    step(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB, 1'b0, 1'b1);
    checkEq("conf1_rob", bus.cdbRobId, 4'd1);
    checkEq("conf1_val", bus.cdbVal,   32'hA);
    idle();
    checkEq("conf2_valid", bus.cdbValid, 1'b1);
    checkEq("conf2_rob",   bus.cdbRobId, 4'd2);
    checkEq("conf2_val",   bus.cdbVal,   32'hB);

    // Sustained contention for 8 cycles, then drain
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 4'(8 + i), 32'h200 + 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) idle();
    checkEq("drain_valid", bus.cdbValid, 1'b0);

    // Ordering: LSB backlog 4,5 then input 6 must not bypass
    doReset();
    step(1'b1, 4'd1, 32'h41, 1'b1, 4'd3, 32'h43, 1'b0, 1'b1);
    step(1'b1, 4'd2, 32'h42, 1'b1, 4'd4, 32'h44, 1'b0, 1'b1);
    step(1'b1, 4'd7, 32'h47, 1'b1, 4'd5, 32'h45, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 4'd6, 32'h46, 1'b0, 1'b1);
    checkEq("order_first", bus.cdbRobId, 4'd4);
    idle();
    checkEq("order_alu", bus.cdbRobId, 4'd7);
    idle();
    checkEq("order_second", bus.cdbRobId, 4'd5);
    idle();
    checkEq("order_third", bus.cdbRobId, 4'd6);
    checkEq("order_third_val", bus.cdbVal, 32'h46);

    // Flush with two entries queued per source plus same-cycle inputs
    doReset();
    step(1'b1, 4'd1, 32'h51, 1'b1, 4'd2, 32'h52, 1'b0, 1'b1);
    step(1'b1, 4'd3, 32'h53, 1'b1, 4'd4, 32'h54, 1'b0, 1'b1);
    step(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h56, 1'b0, 1'b1);
    step(1'b1, 4'd7, 32'h57, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 32'h59, 1'b1, 4'd8, 32'h58, 1'b0, 1'b1);
    step(1'b1, 4'd10, 32'h5A, 1'b1, 4'd11, 32'h5B, 1'b1, 1'b1);
    checkEq("flush_valid", bus.cdbValid, 1'b0);
    checkEq("flush_stall", {bus.aluStall, bus.lsbStall}, 2'b00);
    step(1'b1, 4'd12, 32'h77, 1'b0, '0, '0, 1'b0, 1'b1);
    checkEq("post_flush_valid", bus.cdbValid, 1'b1);
    checkEq("post_flush_rob",   bus.cdbRobId, 4'd12);
    idle();
    checkEq("post_flush_empty", bus.cdbValid, 1'b0);

    // Mid-operation reset with entries queued; lastGrant left at ALU first
    step(1'b1, 4'd1, 32'h61, 1'b1, 4'd2, 32'h62, 1'b0, 1'b1);
    step(1'b1, 4'd3, 32'h63, 1'b1, 4'd4, 32'h64, 1'b0, 1'b1);
    doReset();
    checkEq("mid_rst_valid", bus.cdbValid, 1'b0);
    checkEq("mid_rst_rob",   bus.cdbRobId, 4'd0);
    checkEq("mid_rst_val",   bus.cdbVal,   32'd0);
    checkEq("mid_rst_stall", {bus.aluStall, bus.lsbStall}, 2'b00);
    step(1'b1, 4'd14, 32'hE0, 1'b1, 4'd15, 32'hF0, 1'b0, 1'b1);
    checkEq("post_rst_winner", bus.cdbRobId, 4'd14);

    // Randomized traffic; producers react to stall one cycle late
    pA = 1'b0;
    pL = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic aV;
      logic lV;
      logic fl;
      logic rn;
      curA = (aluQ.size() >= 3);
      curL = (lsbQ.size() >= 3);
      aV = !pA && ($urandom_range(0, 99) < 65);
      lV = !pL && ($urandom_range(0, 99) < 65);
      fl = ($urandom_range(0, 99) < 3);
      rn = !($urandom_range(0, 199) < 2);
      step(aV, 4'($urandom), $urandom, lV, 4'($urandom), $urandom, fl, rn);
      pA = curA;
      pL = curL;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
